// File: rtl/ddr5_cmd_sequencer.sv
// rtl/ddr5_cmd_sequencer.sv - closed-page DDR5 ACT/CAS/PRE command sequencer for a single request at a time
module ddr5_cmd_sequencer #(
    parameter int T_RCD   = 39,
    parameter int T_RAS   = 76,
    parameter int T_RTP   = 18,
    parameter int T_CWL   = 38,
    parameter int T_BURST = 8,
    parameter int T_WR    = 72,
    parameter int T_RP    = 39
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_core,
    input  logic [2:0]  req_opn,
    input  logic [33:0] req_addr,
    output logic        cmd_valid,
    output logic [2:0]  cmd,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_ba,
    output logic [17:0] cmd_row,
    output logic [9:0]  cmd_col,
    output logic        busy,
    output logic        bad_opn
);
    typedef enum logic [3:0] {
        S_IDLE, S_ACT0, S_ACT1, S_WAIT_RCD, S_CAS0, S_CAS1, S_WAIT_PRE, S_PRE, S_WAIT_RP
    } state_t;

    localparam int P_RD = (T_RAS > T_RCD + T_RTP) ? T_RAS : (T_RCD + T_RTP);
    localparam int P_WR = (T_RAS > T_RCD + T_CWL + T_BURST + T_WR) ? T_RAS
                                                                  : (T_RCD + T_CWL + T_BURST + T_WR);

    state_t      r_state;
    state_t      w_next;
    logic        r_phase;
    logic        r_in_rst;
    logic [7:0]  r_n;
    logic        r_wr;
    logic [3:0]  r_core;
    logic [2:0]  r_bg;
    logic [1:0]  r_ba;
    logic [17:0] r_row;
    logic [9:0]  r_col;
    logic        r_bad;

    logic        w_tick;
    logic        w_xfer;
    logic        w_legal;
    logic [7:0]  w_n_inc;
    logic [7:0]  w_pre_n;
    logic [7:0]  w_rp_end;
    logic        w_is_cas;

    assign w_tick    = r_phase;
    assign req_ready = (r_state == S_IDLE) && !r_in_rst;
    assign w_xfer    = req_valid && req_ready;
    assign w_legal   = (req_opn <= 3'd2);
    assign w_n_inc   = r_n + 8'd1;
    assign w_pre_n   = r_wr ? 8'(P_WR) : 8'(P_RD);
    // Leave WAIT_RP at the end of tick P+T_RP-1 so a waiting request can be
    // accepted on the half-tick and land ACT0 exactly on tick P+T_RP.
    assign w_rp_end  = w_pre_n + 8'(T_RP);
    assign busy      = (r_state != S_IDLE);
    assign bad_opn   = r_bad;

    always_comb begin
        w_next    = r_state;
        cmd_valid = 1'b0;
        cmd       = 3'd0;
        w_is_cas  = 1'b0;
        case (r_state)
            S_IDLE:     if (w_xfer && w_legal) w_next = S_ACT0;
            S_ACT0:     if (w_tick) begin
                            cmd_valid = 1'b1;
                            cmd       = 3'd1;
                            w_next    = S_ACT1;
                        end
            S_ACT1:     if (w_tick) begin
                            cmd_valid = 1'b1;
                            cmd       = 3'd2;
                            w_next    = (w_n_inc == 8'(T_RCD)) ? S_CAS0 : S_WAIT_RCD;
                        end
            S_WAIT_RCD: if (w_tick && (w_n_inc == 8'(T_RCD))) w_next = S_CAS0;
            S_CAS0:     if (w_tick) begin
                            cmd_valid = 1'b1;
                            cmd       = r_wr ? 3'd5 : 3'd3;
                            w_is_cas  = 1'b1;
                            w_next    = S_CAS1;
                        end
            S_CAS1:     if (w_tick) begin
                            cmd_valid = 1'b1;
                            cmd       = r_wr ? 3'd6 : 3'd4;
                            w_is_cas  = 1'b1;
                            w_next    = S_WAIT_PRE;
                        end
            S_WAIT_PRE: if (w_tick && (w_n_inc == w_pre_n)) w_next = S_PRE;
            S_PRE:      if (w_tick) begin
                            cmd_valid = 1'b1;
                            cmd       = 3'd7;
                            w_next    = (w_n_inc == w_rp_end) ? S_IDLE : S_WAIT_RP;
                        end
            S_WAIT_RP:  if (w_tick && (w_n_inc == w_rp_end)) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
        cmd_bg  = cmd_valid ? r_bg  : 3'd0;
        cmd_ba  = cmd_valid ? r_ba  : 2'd0;
        cmd_row = cmd_valid ? r_row : 18'd0;
        cmd_col = w_is_cas  ? r_col : 10'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_phase  <= 1'b0;
            r_in_rst <= 1'b1;
            r_n      <= 8'd0;
            r_wr     <= 1'b0;
            r_core   <= 4'd0;
            r_bg     <= 3'd0;
            r_ba     <= 2'd0;
            r_row    <= 18'd0;
            r_col    <= 10'd0;
            r_bad    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_phase  <= ~r_phase;
            r_in_rst <= 1'b0;
            r_bad    <= w_xfer && !w_legal;
            if (r_state == S_IDLE) begin
                r_n <= 8'd0;
            end else if (w_tick) begin
                r_n <= w_n_inc;
            end
            if (w_xfer) begin
                r_wr   <= (req_opn == 3'd1);
                r_core <= req_core;
                r_bg   <= req_addr[9:7];
                r_ba   <= req_addr[11:10];
                r_row  <= req_addr[33:16];
                r_col  <= {req_addr[17:12], req_addr[5:2]};
            end
        end
    end
endmodule

// File: tb/tb_ddr5_cmd_sequencer.sv
// tb/tb_ddr5_cmd_sequencer.sv - directed self-checking bench for ddr5_cmd_sequencer
module tb_ddr5_cmd_sequencer;
    localparam int T_RP = 39;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_core = 4'd0;
    logic [2:0]  req_opn = 3'd0;
    logic [33:0] req_addr = 34'd0;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [17:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        busy;
    logic        bad_opn;
    logic        tb_phase = 1'b0;

    int checks = 0;
    int errors = 0;

    ddr5_cmd_sequencer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_core(req_core), .req_opn(req_opn), .req_addr(req_addr),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .busy(busy), .bad_opn(bad_opn)
    );

    always #5 clk = ~clk;

    // Reference DRAM phase: tick cycles are the odd cycles after the last reset edge.
    always @(posedge clk) tb_phase <= rst ? 1'b0 : ~tb_phase;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic [2:0] opn, input logic [33:0] addr,
                          input int p_ticks, input logic [2:0] e_bg, input logic [1:0] e_ba,
                          input logic [17:0] e_row, input logic [9:0] e_col);
        int          lat;
        int          n;
        int          t_cmd [5];
        logic [2:0]  c_cmd [5];
        logic [9:0]  c_col [5];
        logic [2:0]  c_bg;
        logic [1:0]  c_ba;
        logic [17:0] c_row;
        logic        rdy_a;
        logic        rdy_b;
        logic        e_wr;
        n     = 0;
        c_bg  = 3'd0;
        c_ba  = 2'd0;
        c_row = 18'd0;
        rdy_a = 1'bx;
        rdy_b = 1'bx;
        e_wr  = (opn == 3'd1);
        for (int i = 0; i < 5; i++) begin
            t_cmd[i] = -1;
            c_cmd[i] = 3'd0;
            c_col[i] = 10'd0;
        end
        req_valid = 1'b1;
        req_opn   = opn;
        req_addr  = addr;
        req_core  = 4'hA;
        lat = tb_phase ? 2 : 1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int t = 1; t <= lat + 2 * (p_ticks + T_RP) + 1; t++) begin
            if (cmd_valid) begin
                if (n < 5) begin
                    t_cmd[n] = t;
                    c_cmd[n] = cmd;
                    c_col[n] = cmd_col;
                    if (n == 0) begin
                        c_bg  = cmd_bg;
                        c_ba  = cmd_ba;
                        c_row = cmd_row;
                    end
                end
                n++;
            end
            if (t == lat + 2 * (p_ticks + T_RP) - 2) rdy_a = req_ready;
            if (t == lat + 2 * (p_ticks + T_RP)) rdy_b = req_ready;
            @(negedge clk);
        end
        chk({tag, "_ncmd"}, 64'(n), 64'd5);
        chk({tag, "_act0_t"}, 64'(t_cmd[0]), 64'(lat));
        chk({tag, "_act1_t"}, 64'(t_cmd[1]), 64'(lat + 2));
        chk({tag, "_cas0_t"}, 64'(t_cmd[2]), 64'(lat + 78));
        chk({tag, "_cas1_t"}, 64'(t_cmd[3]), 64'(lat + 80));
        chk({tag, "_pre_t"}, 64'(t_cmd[4]), 64'(lat + 2 * p_ticks));
        chk({tag, "_cmds"}, {49'd0, c_cmd[0], c_cmd[1], c_cmd[2], c_cmd[3], c_cmd[4]},
            {49'd0, 3'd1, 3'd2, e_wr ? 3'd5 : 3'd3, e_wr ? 3'd6 : 3'd4, 3'd7});
        chk({tag, "_bg"}, 64'(c_bg), 64'(e_bg));
        chk({tag, "_ba"}, 64'(c_ba), 64'(e_ba));
        chk({tag, "_row"}, 64'(c_row), 64'(e_row));
        chk({tag, "_col_act0"}, 64'(c_col[0]), 64'd0);
        chk({tag, "_col_cas0"}, 64'(c_col[2]), 64'(e_col));
        chk({tag, "_col_cas1"}, 64'(c_col[3]), 64'(e_col));
        chk({tag, "_rdy_before"}, 64'(rdy_a), 64'd0);
        chk({tag, "_rdy_idle"}, 64'(rdy_b), 64'd1);
    endtask

    initial begin : stim
        int act_t [2];
        int n_act;
        int rdy_hi;
        int n_cmd;
        int lat;
        logic seen;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_cmd", 64'(cmd), 64'd0);
        chk("rst_addr", {31'd0, cmd_bg, cmd_ba, cmd_row, cmd_col}, 64'd0);
        chk("rst_bad", 64'(bad_opn), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", 64'(req_ready), 64'd1);

        do_req("read", 3'd0, 34'h2_ABCD_1E84, 76, 3'd5, 2'd3, 18'h2ABCD, 10'h111);
        do_req("write", 3'd1, 34'h1_2345_6A3C, 157, 3'd4, 2'd2, 18'h12345, 10'h16F);

        // Illegal opn: dropped with a one-cycle flag
        req_valid = 1'b1;
        req_opn   = 3'd5;
        req_addr  = 34'h2_ABCD_1E84;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("ill_bad_pulse", 64'(bad_opn), 64'd1);
        chk("ill_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        chk("ill_bad_clear", 64'(bad_opn), 64'd0);
        n_cmd = 0;
        for (int i = 0; i < 8; i++) begin
            if (cmd_valid || busy) n_cmd++;
            @(negedge clk);
        end
        chk("ill_no_cmd", 64'(n_cmd), 64'd0);
        chk("ill_ready_after", 64'(req_ready), 64'd1);

        do_req("fetch", 3'd2, 34'h2_ABCD_1E84, 76, 3'd5, 2'd3, 18'h2ABCD, 10'h111);

        // Back-to-back reads with req_valid held high
        req_valid = 1'b1;
        req_opn   = 3'd0;
        req_addr  = 34'h2_ABCD_1E84;
        lat    = tb_phase ? 2 : 1;
        n_act  = 0;
        rdy_hi = 0;
        act_t[0] = -1;
        act_t[1] = -1;
        @(posedge clk);
        @(negedge clk);
        for (int t = 1; t <= 300 && n_act < 2; t++) begin
            if (cmd_valid && cmd == 3'd1) begin
                act_t[n_act] = t;
                n_act++;
                if (n_act == 2) req_valid = 1'b0;
            end else if (n_act == 1 && req_ready) begin
                rdy_hi++;
            end
            @(negedge clk);
        end
        chk("b2b_act0_lat", 64'(act_t[0]), 64'(lat));
        chk("b2b_spacing", 64'(act_t[1] - act_t[0]), 64'd230);
        chk("b2b_ready_hi", 64'(rdy_hi), 64'd1);
        seen = 1'b0;
        for (int t = 0; t < 600 && !seen; t++) begin
            if (req_ready) seen = 1'b1;
            else @(negedge clk);
        end
        chk("b2b_drain", 64'(seen), 64'd1);

        // Reset at tick 50 of a write
        req_valid = 1'b1;
        req_opn   = 3'd1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 4 && !seen; t++) begin
            if (cmd_valid && cmd == 3'd1) seen = 1'b1;
            else @(negedge clk);
        end
        chk("rstw_act0", 64'(seen), 64'd1);
        n_cmd = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (cmd_valid) n_cmd++;
        end
        chk("rstw_cmds_before", 64'(n_cmd), 64'd3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstw_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rstw_busy", 64'(busy), 64'd0);
        chk("rstw_ready_in_rst", 64'(req_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_ready_after", 64'(req_ready), 64'd1);
        n_cmd = 0;
        for (int t = 0; t < 400; t++) begin
            if (cmd_valid) n_cmd++;
            @(negedge clk);
        end
        chk("rstw_no_pre", 64'(n_cmd), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
